// File: rtl/controlmux_pkg.sv
// controlmux_pkg: select encoding for the ID-stage control mux (real controls or an all-zero bubble)
package controlmux_pkg;
  typedef enum logic {SEL_CTRL = 1'b0, SEL_ZERO = 1'b1} controlmux_sel_t;
endpackage

// File: rtl/hazard_pkg.sv
// hazard_pkg: FSM state type and limits shared by the hazard control unit
package hazard_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH_PEND = 2'd2} hd_state_t;
  localparam int LOAD_DEPTH_MAX = 2;
endpackage

// File: rtl/hazard_control_unit_if.sv
// hazard_control_unit_if: pipeline <-> hazard unit bundle
//   pipeline side (master) drives ID sources, EX/MEM load info, redirect and cache handshakes;
//   hazard unit side (slave) drives control-mux select, per-stage write enables, flush strobes, counters.
interface hazard_control_unit_if
  import controlmux_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] ID_rs1_i;
  logic [REG_W-1:0] ID_rs2_i;
  logic             ID_rs1_used_i;
  logic             ID_rs2_used_i;
  logic             EX_mem_read_i;
  logic [REG_W-1:0] EX_rd_i;
  logic             MEM_mem_read_i;
  logic [REG_W-1:0] MEM_rd_i;
  logic             EX_redirect_i;
  logic             imem_req_i;
  logic             imem_resp_i;
  logic             dmem_req_i;
  logic             dmem_resp_i;
  controlmux_sel_t  HD_controlmux_sel_o;
  logic             HD_PC_write_o;
  logic             HD_IF_ID_write_o;
  logic             HD_ID_EX_write_o;
  logic             HD_EX_MEM_write_o;
  logic             HD_MEM_WB_write_o;
  logic             HD_IF_ID_flush_o;
  logic             HD_ID_EX_flush_o;
  logic [CNT_W-1:0] HD_stall_cnt_o;
  logic [CNT_W-1:0] HD_flush_cnt_o;
  modport master (
    output ID_rs1_i, ID_rs2_i, ID_rs1_used_i, ID_rs2_used_i, EX_mem_read_i, EX_rd_i,
           MEM_mem_read_i, MEM_rd_i, EX_redirect_i, imem_req_i, imem_resp_i, dmem_req_i, dmem_resp_i,
    input  HD_controlmux_sel_o, HD_PC_write_o, HD_IF_ID_write_o, HD_ID_EX_write_o, HD_EX_MEM_write_o,
           HD_MEM_WB_write_o, HD_IF_ID_flush_o, HD_ID_EX_flush_o, HD_stall_cnt_o, HD_flush_cnt_o
  );
  modport slave (
    input  ID_rs1_i, ID_rs2_i, ID_rs1_used_i, ID_rs2_used_i, EX_mem_read_i, EX_rd_i,
           MEM_mem_read_i, MEM_rd_i, EX_redirect_i, imem_req_i, imem_resp_i, dmem_req_i, dmem_resp_i,
    output HD_controlmux_sel_o, HD_PC_write_o, HD_IF_ID_write_o, HD_ID_EX_write_o, HD_EX_MEM_write_o,
           HD_MEM_WB_write_o, HD_IF_ID_flush_o, HD_ID_EX_flush_o, HD_stall_cnt_o, HD_flush_cnt_o
  );
endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones
//   clk, rst (sync active-low), i_en (count this cycle) -> o_count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;
  always_ff @(posedge clk)
    if (!rst) r_count <= '0;
    else if (i_en && r_count != '1) r_count <= r_count + 1'b1;
  assign o_count = r_count;
endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: pipeline stall/flush controller (load-use bubbles, cache-miss freeze, redirect flush)
//   clk, rst (sync active-low); hd: slave side of hazard_control_unit_if carrying hazard inputs,
//   per-stage write enables, control-mux select, flush strobes and saturating stall/flush counters.
module hazard_control_unit
  import hazard_pkg::*;
  import controlmux_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int LOAD_DEPTH = 1,
  parameter int CNT_W      = 32
) (
  input logic                  clk,
  input logic                  rst,
  hazard_control_unit_if.slave hd
);
  function automatic logic hit(input logic ld, input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs1,
                               input logic [REG_W-1:0] rs2, input logic u1, input logic u2);
    return ld && rd != '0 && ((u1 && rd == rs1) || (u2 && rd == rs2));
  endfunction
  hd_state_t r_state, w_state_nxt;
  logic r_redirect_pend;
  logic w_miss, w_lu, w_freeze, w_flush, w_bubble, w_pend;
  always_comb begin
    w_miss   = (hd.imem_req_i && !hd.imem_resp_i) || (hd.dmem_req_i && !hd.dmem_resp_i);
    w_lu     = hit(hd.EX_mem_read_i, hd.EX_rd_i, hd.ID_rs1_i, hd.ID_rs2_i, hd.ID_rs1_used_i, hd.ID_rs2_used_i) ||
               (LOAD_DEPTH >= LOAD_DEPTH_MAX &&
                hit(hd.MEM_mem_read_i, hd.MEM_rd_i, hd.ID_rs1_i, hd.ID_rs2_i, hd.ID_rs1_used_i, hd.ID_rs2_used_i));
    // MEM_WAIT still freezes on its response cycle so the returning data lands before anything moves
    w_freeze = w_miss || r_state == MEM_WAIT;
    w_flush  = !w_freeze && (r_state == FLUSH_PEND || hd.EX_redirect_i);
    w_bubble = !w_freeze && !w_flush && w_lu;
    w_pend   = r_redirect_pend || hd.EX_redirect_i;
    w_state_nxt = w_miss ? MEM_WAIT : (r_state == MEM_WAIT && w_pend) ? FLUSH_PEND : RUN;
  end
  assign hd.HD_controlmux_sel_o = w_bubble ? SEL_ZERO : SEL_CTRL;
  assign hd.HD_PC_write_o       = !w_freeze && !w_bubble;
  assign hd.HD_IF_ID_write_o    = !w_freeze && !w_bubble;
  assign hd.HD_ID_EX_write_o    = !w_freeze;
  assign hd.HD_EX_MEM_write_o   = !w_freeze;
  assign hd.HD_MEM_WB_write_o   = !w_freeze;
  assign hd.HD_IF_ID_flush_o    = w_flush;
  assign hd.HD_ID_EX_flush_o    = w_flush;
  // a redirect seen while frozen is remembered until the freeze ends; a miss in FLUSH_PEND keeps it pending
  always_ff @(posedge clk)
    if (!rst) begin
      r_state         <= RUN;
      r_redirect_pend <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_redirect_pend <= w_freeze && w_pend;
    end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_freeze || w_bubble),
    .o_count (hd.HD_stall_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_flush),
    .o_count (hd.HD_flush_cnt_o)
  );
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: scoreboard bench driving a LOAD_DEPTH=2/CNT_W=32 and a LOAD_DEPTH=1/CNT_W=4 unit in lockstep
module tb_hazard_control_unit;
  import controlmux_pkg::*;
  // {sel_zero, PC, IF_ID, ID_EX, EX_MEM, MEM_WB write, IF_ID flush, ID_EX flush}
  localparam logic [7:0] IDLE = 8'b0_11111_00;
  localparam logic [7:0] BUB  = 8'b1_00111_00;
  localparam logic [7:0] FRZ  = 8'b0_00000_00;
  localparam logic [7:0] FLS  = 8'b0_11111_11;
  typedef struct packed {
    logic [4:0] rs1, rs2;
    logic       u1, u2, ex_ld;
    logic [4:0] ex_rd;
    logic       mem_ld;
    logic [4:0] mem_rd;
    logic       redir, ireq, iresp, dreq, dresp;
  } stim_t;
  typedef struct {
    string       tag;
    int          idx;
    logic [15:0] want;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  stim_t cur;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  hazard_control_unit_if #(.REG_W(5), .CNT_W(32)) hd_a ();
  hazard_control_unit_if #(.REG_W(5), .CNT_W(4))  hd_b ();
  assign hd_a.ID_rs1_i = cur.rs1;        assign hd_b.ID_rs1_i = cur.rs1;
  assign hd_a.ID_rs2_i = cur.rs2;        assign hd_b.ID_rs2_i = cur.rs2;
  assign hd_a.ID_rs1_used_i = cur.u1;    assign hd_b.ID_rs1_used_i = cur.u1;
  assign hd_a.ID_rs2_used_i = cur.u2;    assign hd_b.ID_rs2_used_i = cur.u2;
  assign hd_a.EX_mem_read_i = cur.ex_ld; assign hd_b.EX_mem_read_i = cur.ex_ld;
  assign hd_a.EX_rd_i = cur.ex_rd;       assign hd_b.EX_rd_i = cur.ex_rd;
  assign hd_a.MEM_mem_read_i = cur.mem_ld; assign hd_b.MEM_mem_read_i = cur.mem_ld;
  assign hd_a.MEM_rd_i = cur.mem_rd;     assign hd_b.MEM_rd_i = cur.mem_rd;
  assign hd_a.EX_redirect_i = cur.redir; assign hd_b.EX_redirect_i = cur.redir;
  assign hd_a.imem_req_i = cur.ireq;     assign hd_b.imem_req_i = cur.ireq;
  assign hd_a.imem_resp_i = cur.iresp;   assign hd_b.imem_resp_i = cur.iresp;
  assign hd_a.dmem_req_i = cur.dreq;     assign hd_b.dmem_req_i = cur.dreq;
  assign hd_a.dmem_resp_i = cur.dresp;   assign hd_b.dmem_resp_i = cur.dresp;
  hazard_control_unit #(.REG_W(5), .LOAD_DEPTH(2), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .hd(hd_a));
  hazard_control_unit #(.REG_W(5), .LOAD_DEPTH(1), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .hd(hd_b));
  logic [7:0] obs_a, obs_b;
  assign obs_a = {hd_a.HD_controlmux_sel_o == SEL_ZERO, hd_a.HD_PC_write_o, hd_a.HD_IF_ID_write_o,
                  hd_a.HD_ID_EX_write_o, hd_a.HD_EX_MEM_write_o, hd_a.HD_MEM_WB_write_o,
                  hd_a.HD_IF_ID_flush_o, hd_a.HD_ID_EX_flush_o};
  assign obs_b = {hd_b.HD_controlmux_sel_o == SEL_ZERO, hd_b.HD_PC_write_o, hd_b.HD_IF_ID_write_o,
                  hd_b.HD_ID_EX_write_o, hd_b.HD_EX_MEM_write_o, hd_b.HD_MEM_WB_write_o,
                  hd_b.HD_IF_ID_flush_o, hd_b.HD_ID_EX_flush_o};
  task automatic reset_dut(input logic rand_in);
    logic [31:0] r;
    rst = 1'b0;
    repeat (2) begin
      r = $urandom;
      cur = rand_in ? r[$bits(stim_t)-1:0] : '0;
      @(posedge clk); #1;
    end
    cur = '0;
    rst = 1'b1;
  endtask
  task automatic test_reset();
    exp_t e;
    reset_dut(1'b1);
    sb.push_back('{"reset_idle", 0, {IDLE, IDLE}});
    @(negedge clk); e = sb.pop_front(); checks++;
    if ({obs_a, obs_b} !== e.want) begin errors++; $display("FAIL %s got a=%b b=%b want %b", e.tag, obs_a, obs_b, e.want); end
    @(posedge clk); #1;
    checks++;
    if (hd_a.HD_stall_cnt_o !== 32'd0 || hd_a.HD_flush_cnt_o !== 32'd0) begin
      errors++; $display("FAIL reset_cnt_a got stall=%0d flush=%0d want 0 0", hd_a.HD_stall_cnt_o, hd_a.HD_flush_cnt_o);
    end
    checks++;
    if (hd_b.HD_stall_cnt_o !== 4'd0 || hd_b.HD_flush_cnt_o !== 4'd0) begin
      errors++; $display("FAIL reset_cnt_b got stall=%0d flush=%0d want 0 0", hd_b.HD_stall_cnt_o, hd_b.HD_flush_cnt_o);
    end
  endtask
  task automatic test_load_use();
    stim_t st[$];
    logic [15:0] ex[$];
    stim_t s;
    exp_t e;
    reset_dut(1'b0);
    s = '0; s.ex_ld = 1; s.ex_rd = 5; s.rs2 = 5; s.u2 = 1; st.push_back(s); ex.push_back({BUB, BUB});
    s = '0; st.push_back(s); ex.push_back({IDLE, IDLE});
    s = '0; s.ex_ld = 1; s.ex_rd = 0; s.rs2 = 0; s.u2 = 1; st.push_back(s); ex.push_back({IDLE, IDLE});
    s = '0; s.ex_ld = 1; s.ex_rd = 5; s.rs2 = 5; s.u2 = 0; st.push_back(s); ex.push_back({IDLE, IDLE});
    s = '0; s.ex_ld = 0; s.ex_rd = 5; s.rs2 = 5; s.u2 = 1; st.push_back(s); ex.push_back({IDLE, IDLE});
    s = '0; s.ex_ld = 1; s.ex_rd = 9; s.rs1 = 9; s.u1 = 1; st.push_back(s); ex.push_back({BUB, BUB});
    foreach (st[i]) begin
      cur = st[i]; sb.push_back('{"load_use", i, ex[i]});
      @(negedge clk); e = sb.pop_front(); checks++;
      if ({obs_a, obs_b} !== e.want) begin errors++; $display("FAIL %s[%0d] got a=%b b=%b want %b", e.tag, e.idx, obs_a, obs_b, e.want); end
      @(posedge clk); #1;
    end
    checks++;
    if (hd_a.HD_stall_cnt_o !== 32'd2) begin errors++; $display("FAIL load_use_stall_cnt got %0d want 2", hd_a.HD_stall_cnt_o); end
  endtask
  task automatic test_load_depth();
    stim_t st[$];
    logic [15:0] ex[$];
    stim_t s;
    exp_t e;
    reset_dut(1'b0);
    s = '0; s.mem_ld = 1; s.mem_rd = 7; s.rs1 = 7; s.u1 = 1; st.push_back(s); ex.push_back({BUB, IDLE});
    s = '0; s.mem_ld = 1; s.mem_rd = 7; s.rs2 = 7; s.u2 = 1; st.push_back(s); ex.push_back({BUB, IDLE});
    s = '0; s.mem_ld = 1; s.mem_rd = 0; s.rs1 = 0; s.u1 = 1; st.push_back(s); ex.push_back({IDLE, IDLE});
    s = '0; s.mem_ld = 0; s.mem_rd = 7; s.rs1 = 7; s.u1 = 1; st.push_back(s); ex.push_back({IDLE, IDLE});
    foreach (st[i]) begin
      cur = st[i]; sb.push_back('{"load_depth", i, ex[i]});
      @(negedge clk); e = sb.pop_front(); checks++;
      if ({obs_a, obs_b} !== e.want) begin errors++; $display("FAIL %s[%0d] got a=%b b=%b want %b", e.tag, e.idx, obs_a, obs_b, e.want); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_imem_miss();
    stim_t st[$];
    logic [15:0] ex[$];
    stim_t s;
    exp_t e;
    reset_dut(1'b0);
    repeat (4) begin s = '0; s.ireq = 1; st.push_back(s); ex.push_back({FRZ, FRZ}); end
    s = '0; s.ireq = 1; s.iresp = 1; s.ex_ld = 1; s.ex_rd = 4; s.rs1 = 4; s.u1 = 1; st.push_back(s); ex.push_back({FRZ, FRZ});
    s = '0; st.push_back(s); ex.push_back({IDLE, IDLE});
    foreach (st[i]) begin
      cur = st[i]; sb.push_back('{"imem_miss", i, ex[i]});
      @(negedge clk); e = sb.pop_front(); checks++;
      if ({obs_a, obs_b} !== e.want) begin errors++; $display("FAIL %s[%0d] got a=%b b=%b want %b", e.tag, e.idx, obs_a, obs_b, e.want); end
      @(posedge clk); #1;
    end
    checks++;
    if (hd_a.HD_stall_cnt_o !== 32'd5 || hd_b.HD_stall_cnt_o !== 4'd5) begin
      errors++; $display("FAIL imem_stall_cnt got a=%0d b=%0d want 5 5", hd_a.HD_stall_cnt_o, hd_b.HD_stall_cnt_o);
    end
  endtask
  task automatic test_redirect_dmiss();
    stim_t st[$];
    logic [15:0] ex[$];
    stim_t s;
    exp_t e;
    reset_dut(1'b0);
    s = '0; s.dreq = 1; st.push_back(s); ex.push_back({FRZ, FRZ});
    s = '0; s.dreq = 1; s.redir = 1; st.push_back(s); ex.push_back({FRZ, FRZ});
    s = '0; s.dreq = 1; st.push_back(s); ex.push_back({FRZ, FRZ});
    s = '0; s.dreq = 1; s.dresp = 1; st.push_back(s); ex.push_back({FRZ, FRZ});
    s = '0; st.push_back(s); ex.push_back({FLS, FLS});
    s = '0; st.push_back(s); ex.push_back({IDLE, IDLE});
    s = '0; st.push_back(s); ex.push_back({IDLE, IDLE});
    foreach (st[i]) begin
      cur = st[i]; sb.push_back('{"redirect_dmiss", i, ex[i]});
      @(negedge clk); e = sb.pop_front(); checks++;
      if ({obs_a, obs_b} !== e.want) begin errors++; $display("FAIL %s[%0d] got a=%b b=%b want %b", e.tag, e.idx, obs_a, obs_b, e.want); end
      @(posedge clk); #1;
    end
    checks++;
    if (hd_a.HD_flush_cnt_o !== 32'd1 || hd_b.HD_flush_cnt_o !== 4'd1 || hd_a.HD_stall_cnt_o !== 32'd4) begin
      errors++; $display("FAIL redirect_dmiss_cnt got flush a=%0d b=%0d stall a=%0d want 1 1 4",
                         hd_a.HD_flush_cnt_o, hd_b.HD_flush_cnt_o, hd_a.HD_stall_cnt_o);
    end
  endtask
  task automatic test_redirect_lu();
    stim_t st[$];
    logic [15:0] ex[$];
    stim_t s;
    exp_t e;
    reset_dut(1'b0);
    s = '0; s.redir = 1; s.ex_ld = 1; s.ex_rd = 3; s.rs1 = 3; s.u1 = 1; st.push_back(s); ex.push_back({FLS, FLS});
    s = '0; s.redir = 1; s.mem_ld = 1; s.mem_rd = 6; s.rs2 = 6; s.u2 = 1; st.push_back(s); ex.push_back({FLS, FLS});
    s = '0; st.push_back(s); ex.push_back({IDLE, IDLE});
    foreach (st[i]) begin
      cur = st[i]; sb.push_back('{"redirect_lu", i, ex[i]});
      @(negedge clk); e = sb.pop_front(); checks++;
      if ({obs_a, obs_b} !== e.want) begin errors++; $display("FAIL %s[%0d] got a=%b b=%b want %b", e.tag, e.idx, obs_a, obs_b, e.want); end
      @(posedge clk); #1;
    end
    checks++;
    if (hd_a.HD_flush_cnt_o !== 32'd2 || hd_a.HD_stall_cnt_o !== 32'd0) begin
      errors++; $display("FAIL redirect_lu_cnt got flush=%0d stall=%0d want 2 0", hd_a.HD_flush_cnt_o, hd_a.HD_stall_cnt_o);
    end
  endtask
  task automatic test_reset_mid_miss();
    stim_t st[$];
    logic [15:0] ex[$];
    stim_t s;
    exp_t e;
    reset_dut(1'b0);
    s = '0; s.dreq = 1; s.redir = 1; cur = s;
    @(posedge clk); #1;
    s.redir = 0; cur = s;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) begin s = '0; st.push_back(s); ex.push_back({IDLE, IDLE}); end
    foreach (st[i]) begin
      cur = st[i]; sb.push_back('{"reset_mid_miss", i, ex[i]});
      @(negedge clk); e = sb.pop_front(); checks++;
      if ({obs_a, obs_b} !== e.want) begin errors++; $display("FAIL %s[%0d] got a=%b b=%b want %b", e.tag, e.idx, obs_a, obs_b, e.want); end
      @(posedge clk); #1;
    end
    checks++;
    if (hd_a.HD_flush_cnt_o !== 32'd0 || hd_a.HD_stall_cnt_o !== 32'd0) begin
      errors++; $display("FAIL reset_mid_miss_cnt got flush=%0d stall=%0d want 0 0", hd_a.HD_flush_cnt_o, hd_a.HD_stall_cnt_o);
    end
  endtask
  task automatic test_saturation();
    stim_t st[$];
    logic [15:0] ex[$];
    stim_t s;
    exp_t e;
    reset_dut(1'b0);
    repeat (20) begin s = '0; s.ireq = 1; st.push_back(s); ex.push_back({FRZ, FRZ}); end
    s = '0; s.ireq = 1; s.iresp = 1; st.push_back(s); ex.push_back({FRZ, FRZ});
    repeat (20) begin s = '0; s.redir = 1; st.push_back(s); ex.push_back({FLS, FLS}); end
    repeat (2) begin s = '0; st.push_back(s); ex.push_back({IDLE, IDLE}); end
    foreach (st[i]) begin
      cur = st[i]; sb.push_back('{"saturation", i, ex[i]});
      @(negedge clk); e = sb.pop_front(); checks++;
      if ({obs_a, obs_b} !== e.want) begin errors++; $display("FAIL %s[%0d] got a=%b b=%b want %b", e.tag, e.idx, obs_a, obs_b, e.want); end
      @(posedge clk); #1;
    end
    checks++;
    if (hd_b.HD_stall_cnt_o !== 4'd15 || hd_b.HD_flush_cnt_o !== 4'd15) begin
      errors++; $display("FAIL sat_cnt_b got stall=%0d flush=%0d want 15 15", hd_b.HD_stall_cnt_o, hd_b.HD_flush_cnt_o);
    end
    checks++;
    if (hd_a.HD_stall_cnt_o !== 32'd21 || hd_a.HD_flush_cnt_o !== 32'd20) begin
      errors++; $display("FAIL sat_cnt_a got stall=%0d flush=%0d want 21 20", hd_a.HD_stall_cnt_o, hd_a.HD_flush_cnt_o);
    end
  endtask
  initial begin
    cur = '0;
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_load_depth();
    test_imem_miss();
    test_redirect_dmiss();
    test_redirect_lu();
    test_reset_mid_miss();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
